// File: rtl/mc_payoff_accum_pkg.sv
// Shared constants and state encoding for the Monte Carlo payoff accumulator.
package mc_payoff_accum_pkg;

    // Default datapath width: unsigned Q16.16 prices, strike and result.
    localparam int unsigned DATA_W_DEFAULT  = 32;
    localparam int unsigned FRAC_W          = 16;

    // Run length shared with the simulation controller.
    localparam int unsigned N_PATHS_DEFAULT = 100000;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccum  = 2'd1,
        StDivide = 2'd2,
        StDone   = 2'd3
    } state_e;

endpackage

// File: rtl/mc_payoff_accum_seq_restoring_div.sv
// Sequential restoring divider: one quotient bit per cycle, DVD_W cycles per divide.
// done pulses for one cycle once the quotient is complete; quotient then holds.
module seq_restoring_div #(
    parameter int unsigned DVD_W = 56,
    parameter int unsigned DVS_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int unsigned CntW = $clog2(DVD_W + 1);

    // quo_q starts as the dividend; its MSB is shifted out into the partial
    // remainder while quotient bits are shifted in at the LSB.
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DVS_W:0]   shifted;
    logic [DVS_W:0]   diff;
    logic             ge;

    // Trial subtraction and next-state for the divider registers.
    always_comb begin
        shifted = {rem_q, quo_q[DVD_W-1]};
        diff    = shifted - {1'b0, dvs_q};
        ge      = (shifted >= {1'b0, dvs_q});

        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (abort) begin
            quo_d  = '0;
            rem_d  = '0;
            dvs_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
            cnt_d  = CntW'(DVD_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            quo_d = {quo_q[DVD_W-2:0], ge};
            rem_d = ge ? diff[DVS_W-1:0] : shifted[DVS_W-1:0];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/mc_payoff_accum.sv
// European call/put payoff accumulator: sums per-path payoffs against a latched
// strike, then divides by the accepted path count to give the mean payoff.
module mc_payoff_accum
    import mc_payoff_accum_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned ACC_W   = 56,
    parameter int unsigned CNT_W   = 17,
    parameter int unsigned N_PATHS = N_PATHS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] strike,
    input  logic              is_put,
    input  logic              engine_done,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_price,
    output logic              s_ready,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    output logic              overflow,
    output logic [CNT_W-1:0]  path_count
);

    localparam logic [CNT_W-1:0] NPathsCnt = CNT_W'(N_PATHS);
    localparam logic [ACC_W-1:0] AccMax    = '1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] strike_q, strike_d;
    logic              is_put_q, is_put_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              rvalid_q, rvalid_d;

    logic [DATA_W-1:0] payoff;
    logic [ACC_W:0]    payoff_ext;
    logic [ACC_W:0]    acc_sum;
    logic [CNT_W-1:0]  count_inc;
    logic              xfer;

    logic              div_start;
    logic              div_done;
    logic [ACC_W-1:0]  div_quo;

    // Payoff against the latched strike; never negative.
    always_comb begin
        payoff = '0;
        if (is_put_q) begin
            if (strike_q > s_price) begin
                payoff = strike_q - s_price;
            end
        end else begin
            if (s_price > strike_q) begin
                payoff = s_price - strike_q;
            end
        end
    end

    assign payoff_ext = {{(ACC_W + 1 - DATA_W){1'b0}}, payoff};
    assign acc_sum    = {1'b0, acc_q} + payoff_ext;
    assign count_inc  = count_q + 1'b1;
    assign xfer       = s_valid && (state_q == StAccum);

    // Run control: accumulate, hand off to the divider, publish the result.
    always_comb begin
        state_d   = state_q;
        strike_d  = strike_q;
        is_put_d  = is_put_q;
        acc_d     = acc_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        rvalid_d  = rvalid_q;
        div_start = 1'b0;

        case (state_q)
            StAccum: begin
                if (xfer) begin
                    count_d = count_inc;
                    if (acc_sum[ACC_W]) begin
                        acc_d = AccMax;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = acc_sum[ACC_W-1:0];
                    end
                end
                // A sample in the exit cycle is already folded into acc_d/count_d.
                if (engine_done || (xfer && (count_inc == NPathsCnt))) begin
                    if (count_d == '0) begin
                        state_d  = StDone;
                        result_d = '0;
                        rvalid_d = 1'b1;
                    end else begin
                        state_d   = StDivide;
                        div_start = 1'b1;
                    end
                end
            end
            StDivide: begin
                if (div_done) begin
                    state_d  = StDone;
                    rvalid_d = 1'b1;
                    if (|div_quo[ACC_W-1:DATA_W]) begin
                        result_d = '1;
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = div_quo[DATA_W-1:0];
                    end
                end
            end
            default: ;
        endcase

        // start wins from any state and discards whatever was in flight.
        if (start) begin
            state_d   = StAccum;
            strike_d  = strike;
            is_put_d  = is_put;
            acc_d     = '0;
            count_d   = '0;
            ovf_d     = 1'b0;
            result_d  = '0;
            rvalid_d  = 1'b0;
            div_start = 1'b0;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            strike_q <= '0;
            is_put_q <= 1'b0;
            acc_q    <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            strike_q <= strike_d;
            is_put_q <= is_put_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Divider loads the final sum and count on the exit edge itself.
    seq_restoring_div #(
        .DVD_W (ACC_W),
        .DVS_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .abort    (start),
        .start    (div_start),
        .dividend (acc_d),
        .divisor  (count_d),
        .done     (div_done),
        .quotient (div_quo)
    );

    assign s_ready      = (state_q == StAccum);
    assign busy         = (state_q == StAccum) || (state_q == StDivide);
    assign result       = result_q;
    assign result_valid = rvalid_q;
    assign overflow     = ovf_q;
    assign path_count   = count_q;

endmodule

// File: tb/tb_mc_payoff_accum.sv
// Self-checking bench: directed and randomized runs against an arithmetic model.
module tb_mc_payoff_accum;

    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 17;
    localparam int unsigned ACC_A = 56;
    localparam int unsigned ACC_B = 34;
    localparam int unsigned NP_A  = 4;
    localparam int unsigned NP_B  = 8;

    logic          clk = 1'b0;
    logic          rst, start, is_put, engine_done, s_valid, sel;
    logic [DW-1:0] strike, s_price;

    logic          a_s_ready, a_result_valid, a_busy, a_overflow;
    logic [DW-1:0] a_result;
    logic [CW-1:0] a_path_count;
    logic          b_s_ready, b_result_valid, b_busy, b_overflow;
    logic [DW-1:0] b_result;
    logic [CW-1:0] b_path_count;

    logic          s_ready, result_valid, busy, overflow;
    logic [DW-1:0] result;
    logic [CW-1:0] path_count;

    int            n_checks = 0;
    int            n_err    = 0;
    logic [DW-1:0] px [0:15];

    always #5 clk = ~clk;

    mc_payoff_accum #(
        .DATA_W (DW), .ACC_W (ACC_A), .CNT_W (CW), .N_PATHS (NP_A)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .start        (start & ~sel),
        .strike       (strike),
        .is_put       (is_put),
        .engine_done  (engine_done & ~sel),
        .s_valid      (s_valid & ~sel),
        .s_price      (s_price),
        .s_ready      (a_s_ready),
        .result       (a_result),
        .result_valid (a_result_valid),
        .busy         (a_busy),
        .overflow     (a_overflow),
        .path_count   (a_path_count)
    );

    mc_payoff_accum #(
        .DATA_W (DW), .ACC_W (ACC_B), .CNT_W (CW), .N_PATHS (NP_B)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .start        (start & sel),
        .strike       (strike),
        .is_put       (is_put),
        .engine_done  (engine_done & sel),
        .s_valid      (s_valid & sel),
        .s_price      (s_price),
        .s_ready      (b_s_ready),
        .result       (b_result),
        .result_valid (b_result_valid),
        .busy         (b_busy),
        .overflow     (b_overflow),
        .path_count   (b_path_count)
    );

    assign s_ready      = sel ? b_s_ready      : a_s_ready;
    assign result       = sel ? b_result       : a_result;
    assign result_valid = sel ? b_result_valid : a_result_valid;
    assign busy         = sel ? b_busy         : a_busy;
    assign overflow     = sel ? b_overflow     : a_overflow;
    assign path_count   = sel ? b_path_count   : a_path_count;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pay(input logic [DW-1:0] s, input logic [DW-1:0] k,
                                        input logic put);
        if (put) return (k > s) ? 64'(k - s) : 64'd0;
        return (s > k) ? 64'(s - k) : 64'd0;
    endfunction

    // One complete run on the selected DUT using px[0..n-1], checked against the model.
    task automatic run_check(input string tag, input logic [DW-1:0] k, input logic put,
                             input int n, input bit done_with_last);
        logic [63:0] sum, accmax, mean, exp_res, p;
        bit          exp_ovf;
        int          cyc, exp_lat, accw, np;
        accw   = sel ? ACC_B : ACC_A;
        np     = sel ? NP_B : NP_A;
        accmax = (64'd1 << accw) - 64'd1;
        strike = k;
        is_put = put;
        start  = 1'b1;
        step();
        start  = 1'b0;
        chk({tag, "/cleared_count"}, 64'(path_count), 64'd0);
        chk({tag, "/cleared_valid"}, 64'(result_valid), 64'd0);
        sum     = 64'd0;
        exp_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_price = px[i];
            s_valid = 1'b1;
            if (i == n - 1 && n < np && done_with_last) engine_done = 1'b1;
            step();
            s_valid     = 1'b0;
            engine_done = 1'b0;
            p = pay(px[i], k, put);
            if (sum + p > accmax) begin
                sum     = accmax;
                exp_ovf = 1'b1;
            end else begin
                sum = sum + p;
            end
        end
        if (n < np && (!done_with_last || n == 0)) begin
            engine_done = 1'b1;
            step();
            engine_done = 1'b0;
        end
        // Offer a sample after the run has ended; it must not be counted.
        s_valid = 1'b1;
        s_price = 32'h0001_0000;
        cyc = 0;
        while (!result_valid && cyc < 300) begin
            step();
            cyc++;
            if (cyc == 5) begin
                chk({tag, "/busy_div"}, 64'(busy), 64'd1);
                chk({tag, "/ready_div"}, 64'(s_ready), 64'd0);
            end
        end
        s_valid = 1'b0;
        if (n == 0) begin
            exp_res = 64'd0;
            exp_lat = 0;
        end else begin
            mean    = sum / 64'(n);
            exp_lat = accw + 1;
            if (mean > 64'hFFFF_FFFF) begin
                exp_res = 64'hFFFF_FFFF;
                exp_ovf = 1'b1;
            end else begin
                exp_res = mean;
            end
        end
        chk({tag, "/latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "/result"}, 64'(result), exp_res);
        chk({tag, "/valid"}, 64'(result_valid), 64'd1);
        chk({tag, "/overflow"}, 64'(overflow), 64'(exp_ovf));
        chk({tag, "/count"}, 64'(path_count), 64'(n));
        chk({tag, "/busy_done"}, 64'(busy), 64'd0);
        step();
        chk({tag, "/hold"}, 64'(result), exp_res);
    endtask

    initial begin
        logic [DW-1:0] k;
        logic          put;
        int            n;
        rst = 1'b1; start = 1'b0; is_put = 1'b0; engine_done = 1'b0;
        s_valid = 1'b0; sel = 1'b0; strike = '0; s_price = '0;
        step(); step(); step();

        chk("rst/result", 64'(result), 64'd0);
        chk("rst/valid", 64'(result_valid), 64'd0);
        chk("rst/busy", 64'(busy), 64'd0);
        chk("rst/overflow", 64'(overflow), 64'd0);
        chk("rst/count", 64'(path_count), 64'd0);
        chk("rst/ready", 64'(s_ready), 64'd0);
        rst = 1'b0;
        step();
        chk("idle/ready", 64'(s_ready), 64'd0);

        // Directed call and put runs, K = 100.0
        px[0] = 32'd110 << 16; px[1] = 32'd90 << 16;
        px[2] = 32'd120 << 16; px[3] = 32'd100 << 16;
        run_check("call4", 32'd100 << 16, 1'b0, 4, 1'b0);
        chk("call4/const", 64'(result), 64'h0007_8000);
        run_check("put4", 32'd100 << 16, 1'b1, 4, 1'b0);
        chk("put4/const", 64'(result), 64'h0002_8000);

        // Early end after three calls
        px[0] = 32'd105 << 16; px[1] = 32'd101 << 16; px[2] = 32'd100 << 16;
        run_check("done3", 32'd100 << 16, 1'b0, 3, 1'b0);
        chk("done3/const", 64'(result), 64'h0002_0000);
        s_valid = 1'b1; step(); s_valid = 1'b0;
        chk("done3/no_accept", 64'(path_count), 64'd3);

        // Zero samples
        run_check("zero", 32'd100 << 16, 1'b0, 0, 1'b0);

        // engine_done coincident with the final sample
        px[0] = 32'd7 << 16; px[1] = 32'd3 << 16;
        run_check("coinc", 32'd0, 1'b0, 2, 1'b1);

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            k   = $urandom;
            put = 1'($urandom_range(0, 1));
            n   = $urandom_range(0, 4);
            for (int i = 0; i < 4; i++) px[i] = $urandom;
            run_check($sformatf("rand%0d", r), k, put, n, 1'($urandom_range(0, 1)));
        end

        // start during DIVIDE aborts the run
        strike = 32'd0; is_put = 1'b0; start = 1'b1; step(); start = 1'b0;
        s_price = 32'd50 << 16; s_valid = 1'b1; step(); step(); s_valid = 1'b0;
        engine_done = 1'b1; step(); engine_done = 1'b0;
        step(); step(); step(); step(); step();
        chk("abort_div/busy", 64'(busy), 64'd1);
        px[0] = 32'd4 << 16; px[1] = 32'd6 << 16;
        run_check("after_div_abort", 32'd0, 1'b0, 2, 1'b0);
        chk("after_div_abort/const", 64'(result), 64'h0005_0000);

        // rst during ACCUM
        strike = 32'd0; start = 1'b1; step(); start = 1'b0;
        s_price = 32'd99 << 16; s_valid = 1'b1; step(); s_valid = 1'b0;
        chk("accum/count1", 64'(path_count), 64'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid/count", 64'(path_count), 64'd0);
        chk("rst_mid/busy", 64'(busy), 64'd0);
        chk("rst_mid/valid", 64'(result_valid), 64'd0);
        run_check("after_rst", 32'd0, 1'b0, 2, 1'b0);
        chk("after_rst/const", 64'(result), 64'h0005_0000);

        // Narrow accumulator: saturation
        sel = 1'b1;
        for (int i = 0; i < 8; i++) px[i] = 32'hFFFF_FFFF;
        run_check("sat5", 32'd0, 1'b0, 5, 1'b0);
        chk("sat5/ovf_const", 64'(overflow), 64'd1);
        run_check("sat1", 32'd0, 1'b0, 1, 1'b0);
        chk("sat1/const", 64'(result), 64'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) px[i] = $urandom;
        run_check("b_full", $urandom, 1'($urandom_range(0, 1)), 8, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_payoff_accum.md
Name: mc_payoff_accum

Overview:
- Downstream of the Monte Carlo simulation engine controller and its path pipeline.
- Consumes one terminal asset price per simulated path and computes the European call or put payoff against a latched strike.
- Accumulates payoffs over the path run, then divides by the path count with a sequential restoring divider.
- Presents the mean discounted-input payoff (the option price estimate) to the host/display logic.

Parameters:
- DATA_W, 32, width of prices, strike and result; unsigned Q16.16.
- ACC_W, 56, accumulator and dividend width.
- CNT_W, 17, path counter width.
- N_PATHS, 100000, path count that ends a run; must fit in CNT_W.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  single-cycle pulse: latch strike/is_put, clear accumulator, enter ACCUM
- strike  input  DATA_W  strike price K, sampled on start
- is_put  input  1  1 = put payoff, 0 = call payoff; sampled on start
- engine_done  input  1  end-of-run pulse from the simulation controller
- s_valid  input  1  terminal price valid
- s_price  input  DATA_W  terminal price S_T
- s_ready  output  DATA_W-independent 1  accept strobe; high only in ACCUM
- result  output  DATA_W  mean payoff, Q16.16
- result_valid  output  1  result stable; held until the next start
- busy  output  1  high in ACCUM or DIVIDE
- overflow  output  1  sticky: accumulator or quotient saturated this run
- path_count  output  CNT_W  paths accepted this run

Behaviour:
- Reset values: state IDLE; all outputs 0; accumulator, counter and divider registers 0.
- States: IDLE, ACCUM, DIVIDE, DONE.
- IDLE, DONE:
  - s_ready = 0.
  - start -> ACCUM, clearing acc, count, overflow and result_valid on the same edge.
  - DONE holds result and result_valid = 1.
- ACCUM:
  - s_ready = 1. A transfer occurs when s_valid && s_ready.
  - Payoff is computed combinationally: call = (S > K) ? S - K : 0; put = (K > S) ? K - S : 0.
  - On transfer, acc += zero-extended payoff and count += 1. On carry-out of acc, acc saturates to all-ones and overflow is set.
  - Exit to DIVIDE when, after the transfer, count == N_PATHS, or when engine_done = 1.
  - A sample arriving in the same cycle as engine_done or as the final count is counted before exit.
  - If the exit occurs with count == 0: result = 0, go straight to DONE.
- DIVIDE:
  - Restoring divide of acc by count, one quotient bit per cycle for exactly ACC_W cycles, then DONE.
  - If the quotient exceeds 2^DATA_W - 1, result = all-ones and overflow is set; otherwise result = quotient[DATA_W-1:0] (floor).
  - Latency from the exit edge to result_valid is ACC_W + 1 cycles.
- Any state: start -> abort the current run and restart in ACCUM. A start received in ACCUM or DIVIDE discards partial results.
- rst at any time returns to IDLE with reset values; a partial run is lost.
- Once s_ready is low, s_valid is ignored and no sample is counted.
- engine_done outside ACCUM is ignored.

Decomposition:
- Shared package contents:
  - state encoding constants (IDLE, ACCUM, DIVIDE, DONE);
  - DATA_W and Q16.16 fraction-bit constant;
  - N_PATHS default, shared with the simulation controller's run length.
- One natural sub-module, seq_restoring_div: ACC_W-bit dividend, CNT_W-bit divisor, start/done handshake, one bit per cycle.

Test Plan:
- Call, N_PATHS=4, K=100.0, S = 110.0, 90.0, 120.0, 100.0 -> payoffs 10, 0, 20, 0; result = 7.5 (0x0007_8000); path_count = 4; result_valid high after ACC_W+1 cycles.
- Put, N_PATHS=4, K=100.0, same S -> result = 2.5 (0x0002_8000); overflow = 0.
- engine_done after 3 calls (S = 105, 101, 100; K = 100) -> divide by 3: result = floor(6.0 / 3) = 2.0. A 4th s_valid after done is not accepted.
- engine_done with zero samples -> DONE next cycle; result = 0; result_valid = 1; no divide cycles.
- ACC_W = 34, call K=0, repeated S = 0xFFFF_FFFF -> overflow = 1; result = 0xFFFF_FFFF.
- start mid-DIVIDE, and separately rst mid-ACCUM -> counters and acc cleared. A fresh 2-sample run (payoffs 4.0, 6.0) yields 5.0 with no residue from the aborted run.
